esp_uart_rx_fifo: RTL
=====================

// Module: esp_uart_rx_fifo
// PURPOSE
//  Receive buffer directly downstream of the ESP UART receiver. Captures each
//  rx_valid byte and each break event into a first-word-fall-through FIFO.
//  Keeps sticky overflow, framing and break status bits and raises a level
//  interrupt for the CPU-side register interface.
// PARAMETERS
//  DEPTH_LOG2  4  FIFO depth = 2**DEPTH_LOG2 entries, each 9 bits {is_break, data[7:0]}
//  IRQ_LEVEL   1  irq asserts when count >= IRQ_LEVEL (1..2**DEPTH_LOG2)
// PORTS
//  clk            in   1             system clock; single clock domain
//  rst_n          in   1             asynchronous, active-low reset
//  rx_data        in   8             byte from receiver, qualified by rx_valid
//  rx_valid       in   1             one-cycle push strobe
//  framing_error  in   1             receiver framing-error level
//  break          in   1             receiver break level (held for the duration of the break)
//  rd_data        out  8             head entry data (FWFT)
//  rd_break       out  1             head entry is a break marker (rd_data = 8'h00)
//  rd_valid       out  1             FIFO not empty
//  rd_ack         in   1             pop head; ignored when rd_valid=0
//  flush          in   1             empty the FIFO
//  count          out  DEPTH_LOG2+1  number of stored entries
//  overflow       out  1             sticky: a push was dropped because the FIFO was full
//  framing_seen   out  1             sticky: rising edge of framing_error seen
//  break_seen     out  1             sticky: rising edge of break seen
//  clr_status     in   1             clear all three sticky bits
//  irq            out  1             (count >= IRQ_LEVEL) | overflow | break_seen
// BEHAVIOUR
//  - Reset: count=0, rd_valid=0, rd_data=0, rd_break=0, overflow=0, framing_seen=0,
//    break_seen=0, irq=0, read and write pointers 0, edge registers 0.
//  - Push sources:
//    * rx_valid pushes {0, rx_data}.
//    * The rising edge of break (break=1, previous cycle 0) pushes {1, 8'h00}.
//      Exactly one marker is pushed per break event.
//    * When both sources fire in the same cycle, the byte is pushed and the
//      marker is dropped. This is not an overflow; break_seen is still set.
//  - Pointers: DEPTH_LOG2 bits wide, wrap modulo depth. count is tracked
//    separately. full = (count == 2**DEPTH_LOG2). empty = (count == 0).
//  - Latency: an entry pushed in cycle N appears on rd_data/rd_break with
//    rd_valid=1 in cycle N+1.
//  - rd_data and rd_break always reflect the head entry. They are don't-care
//    while rd_valid=0.
//  - Pop: rd_ack=1 with rd_valid=1 advances the read pointer. The next entry,
//    if any, is visible in the following cycle.
//  - Push while full:
//    * Without a pop: the push is dropped, overflow is set and stored data is
//      unchanged.
//    * With a pop in the same cycle: both are performed, count stays at full,
//      overflow is not set.
//  - Push and pop together while not empty: both are performed and count is
//    unchanged.
//  - Pop while empty: no effect.
//  - flush has the highest priority. Pointers and count go to 0 next cycle.
//    A push or pop in the flush cycle is discarded and does not set overflow.
//    Sticky bits are unaffected.
//  - Sticky bits: set on their event, cleared by clr_status. If set and clear
//    occur in the same cycle, set wins.
//  - framing_error only sets framing_seen and never writes the FIFO. The
//    receiver suppresses rx_valid for errored frames.
//  - irq is a registered copy of its equation and lags the state by one cycle.
//  - Assertion: count never exceeds 2**DEPTH_LOG2.
// TESTING
//  1. Push 0x41, 0x42, 0x43 in separate cycles, no reads -> count=3, rd_data=0x41,
//     rd_valid=1; three rd_ack pulses yield 0x41, 0x42, 0x43, then rd_valid=0, count=0.
//  2. DEPTH_LOG2=4: push 16 bytes, then a 17th (0xEE) with no read -> count=16,
//     overflow=1, 0xEE absent on drain; repeat with rd_ack on the 17th -> overflow=0.
//  3. Raise break for 50 cycles -> exactly one entry, rd_break=1, rd_data=0x00,
//     break_seen=1, irq=1; clr_status after drain -> break_seen=0, irq=0.
//  4. Pulse framing_error for 10 cycles -> framing_seen=1, count unchanged;
//     clr_status in the same cycle as a new rising edge -> framing_seen stays 1.
//  5. With 5 entries, assert flush together with rx_valid and rd_ack -> next cycle
//     count=0, rd_valid=0, overflow=0; the pointer wrap is exercised by 40 push/pop pairs.
//  6. Assert rst_n=0 asynchronously mid-stream with count=7 and overflow=1 -> all
//     outputs 0 immediately; FIFO usable again after release.

Source files
------------

// File: rtl/esp_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// esp_uart_rx_fifo
//
// Receive buffer that sits directly after the ESP UART receiver. Each received
// byte and each break event is stored in a first-word-fall-through FIFO.
// Sticky overflow, framing and break status bits are kept here, and a
// registered level interrupt is raised for the CPU-side register block.
//
// Entry format: {is_break, data[7:0]}. A break marker is stored as {1, 8'h00}.
//
// Ports
//   clk            in   1             system clock, single domain
//   rst_n          in   1             asynchronous active-low reset
//   rx_data        in   8             received byte, qualified by rx_valid
//   rx_valid       in   1             one-cycle push strobe
//   framing_error  in   1             receiver framing-error level
//   rx_break       in   1             receiver break level, held for the whole
//                                     break ('break' is a reserved word)
//   rd_data        out  8             head entry data (FWFT)
//   rd_break       out  1             head entry is a break marker
//   rd_valid       out  1             FIFO not empty
//   rd_ack         in   1             pop head; ignored while rd_valid=0
//   flush          in   1             empty the FIFO (highest priority)
//   count          out  DEPTH_LOG2+1  number of stored entries
//   overflow       out  1             sticky: push dropped while full
//   framing_seen   out  1             sticky: framing_error rising edge seen
//   break_seen     out  1             sticky: rx_break rising edge seen
//   clr_status     in   1             clear the three sticky bits
//   irq            out  1             registered (count>=IRQ_LEVEL)|overflow|break_seen
// -----------------------------------------------------------------------------
module esp_uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int IRQ_LEVEL  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  framing_error,
  input  logic                  rx_break,
  output logic [7:0]            rd_data,
  output logic                  rd_break,
  output logic                  rd_valid,
  input  logic                  rd_ack,
  input  logic                  flush,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  framing_seen,
  output logic                  break_seen,
  input  logic                  clr_status,
  output logic                  irq
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam int                CW       = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]     IRQ_CNT  = CW'(IRQ_LEVEL);

  logic [8:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  break_q, framing_q;

  logic                  break_rise, framing_rise;
  logic                  full, empty;
  logic                  push_req, pop, do_push, ovf_set;
  logic [8:0]            wdata, head;

  // ---------------------------------------------------------------------------
  // Push / pop qualification
  // ---------------------------------------------------------------------------
  assign break_rise   = rx_break & ~break_q;
  assign framing_rise = framing_error & ~framing_q;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A byte and a break marker in the same cycle: the byte wins and the marker
  // is silently dropped (not an overflow).
  assign push_req = rx_valid | break_rise;
  assign wdata    = rx_valid ? {1'b0, rx_data} : {1'b1, 8'h00};

  assign pop      = rd_ack & ~empty & ~flush;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_push  = push_req & (~full | pop) & ~flush;
  assign ovf_set  = push_req & full & ~pop & ~flush;

  // ---------------------------------------------------------------------------
  // Pointers and count
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through count-qualified outputs, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // ---------------------------------------------------------------------------
  // Edge detectors, sticky status and interrupt
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      break_q      <= 1'b0;
      framing_q    <= 1'b0;
      overflow     <= 1'b0;
      framing_seen <= 1'b0;
      break_seen   <= 1'b0;
      irq          <= 1'b0;
    end else begin
      break_q      <= rx_break;
      framing_q    <= framing_error;
      // Set wins over a simultaneous clear.
      overflow     <= ovf_set      | (overflow     & ~clr_status);
      framing_seen <= framing_rise | (framing_seen & ~clr_status);
      break_seen   <= break_rise   | (break_seen   & ~clr_status);
      // Built from the current registered state, so irq trails it by a cycle.
      irq          <= (count >= IRQ_CNT) | overflow | break_seen;
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT read side; outputs forced to zero while empty so reset reads as 0.
  // ---------------------------------------------------------------------------
  assign head     = mem[rd_ptr];
  assign rd_valid = ~empty;
  assign rd_data  = rd_valid ? head[7:0] : 8'h00;
  assign rd_break = rd_valid ? head[8]   : 1'b0;

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n) count <= FULL_CNT);

endmodule
